// File: rtl/seg7_disp_arbiter.sv
// seg7_disp_arbiter: round-robin owner selection for a shared 8-digit
// seven-segment display. Each grant lasts at least HOLD_CYCLES cycles.
// After that, the owner can be preempted by any other pending requester.
// Optional feature macro: SEG7_ARB_LOCK_EN. It adds lock_i, which lets an
// owner refuse preemption once its minimum hold time has expired.
module seg7_disp_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                        pclk_i,
  input  logic                        presetn_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0][31:0]      val_i,
`ifdef SEG7_ARB_LOCK_EN
  input  logic [N_REQ-1:0]            lock_i,
`endif
  output logic [N_REQ-1:0]            gnt_o,
  output logic [$clog2(N_REQ)-1:0]    owner_o,
  output logic [31:0]                 num_o,
  output logic                        disp_en_o,
  output logic                        switch_o
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_OPEN = 2'd2;

  logic [1:0]       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [OW-1:0]    rr_ptr, rr_n;
  logic [OW-1:0]    owner_n;
  logic [N_REQ-1:0] gnt_n;
  logic [31:0]      num_n;
  logic             en_n, sw_n;

  logic [N_REQ-1:0] cand;
  logic [OW-1:0]    win;
  logic             found;
  logic             owner_req, locked, eval_open, do_grant, go_idle;

  // Candidates are every requester except the current owner. While idle, gnt is zero, so all requesters qualify.
  always_comb begin
    cand  = req_i & ~gnt_o;
    win   = rr_ptr;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && cand[(int'(rr_ptr) + i) % N_REQ]) begin
        found = 1'b1;
        win   = OW'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  // Next-state decision: grant or switch, release to idle, or keep the owner.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rr_n      = rr_ptr;
    owner_n   = owner_o;
    gnt_n     = gnt_o;
    num_n     = num_o;
    en_n      = disp_en_o;
    sw_n      = 1'b0;
    do_grant  = 1'b0;
    go_idle   = 1'b0;
    owner_req = req_i[owner_o];
`ifdef SEG7_ARB_LOCK_EN
    locked    = lock_i[owner_o] & owner_req;
`else
    locked    = 1'b0;
`endif
    eval_open = (state == S_OPEN) || ((state == S_HOLD) && owner_req && (cnt == '0));

    if (state == S_IDLE) begin
      do_grant = found;
    end else if (eval_open) begin
      if (found && !locked) begin
        do_grant = 1'b1;
      end else if (!owner_req) begin
        go_idle = 1'b1;
      end else begin
        state_n = S_OPEN;
        cnt_n   = '0;
      end
    end else if (state == S_HOLD) begin
      if (!owner_req) begin
        do_grant = found;
        go_idle  = !found;
      end else begin
        cnt_n = cnt - 1'b1;
      end
    end else begin
      go_idle = 1'b1;
    end

    if (do_grant) begin
      state_n      = S_HOLD;
      cnt_n        = RELOAD;
      rr_n         = win;
      owner_n      = win;
      gnt_n        = '0;
      gnt_n[win]   = 1'b1;
      num_n        = val_i[win];
      en_n         = 1'b1;
      sw_n         = (state != S_IDLE);
    end else if (go_idle) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      gnt_n   = '0;
      en_n    = 1'b0;
    end else if (state != S_IDLE) begin
      num_n = val_i[owner_o];
    end
  end

  // Register all state and outputs. rr_ptr resets to the last index so that requester 0 wins first.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rr_ptr    <= OW'(N_REQ - 1);
      owner_o   <= '0;
      gnt_o     <= '0;
      num_o     <= '0;
      disp_en_o <= 1'b0;
      switch_o  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rr_ptr    <= rr_n;
      owner_o   <= owner_n;
      gnt_o     <= gnt_n;
      num_o     <= num_n;
      disp_en_o <= en_n;
      switch_o  <= sw_n;
    end
  end

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// tb_seg7_disp_arbiter: directed scenarios for seg7_disp_arbiter with N_REQ=4 and HOLD_CYCLES=4.
// A grant-age model is compared against the DUT on every cycle.
// Define SEG7_ARB_LOCK_EN to include the lock scenario.
module tb_seg7_disp_arbiter;

  localparam int NR   = 4;
  localparam int HOLD = 4;

  logic             pclk;
  logic             presetn;
  logic [3:0]       req;
  logic [3:0][31:0] val;
  logic [3:0]       lock;
  logic [3:0]       gnt;
  logic [1:0]       owner;
  logic [31:0]      num;
  logic             disp_en;
  logic             sw;

  int n_compared = 0;
  int n_mismatch = 0;
  bit chk_en = 0;

  seg7_disp_arbiter #(.N_REQ(NR), .HOLD_CYCLES(HOLD)) dut (
    .pclk_i(pclk),
    .presetn_i(presetn),
    .req_i(req),
    .val_i(val),
`ifdef SEG7_ARB_LOCK_EN
    .lock_i(lock),
`endif
    .gnt_o(gnt),
    .owner_o(owner),
    .num_o(num),
    .disp_en_o(disp_en),
    .switch_o(sw)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  typedef struct packed {
    logic        active;
    int          owner;
    int          rr;
    int          held;
    logic [31:0] num;
    logic        sw;
  } model_t;

  localparam model_t MODEL_RESET = '{active: 1'b0, owner: 0, rr: NR - 1, held: 0, num: 32'h0, sw: 1'b0};

  model_t m;

  function automatic int pick(logic [3:0] c, int after);
    for (int i = 1; i <= NR; i++) begin
      if (c[(after + i) % NR]) return (after + i) % NR;
    end
    return 0;
  endfunction

  // held counts edges since the grant. Preemption is allowed once held reaches HOLD.
  function automatic model_t model_step(model_t cur, logic [3:0] r, logic [3:0][31:0] v, logic [3:0] lk);
    model_t     n = cur;
    logic [3:0] others;
    int         held_now;
    int         w;
    n.sw = 1'b0;
    if (!cur.active) begin
      if (r != 4'b0) begin
        w = pick(r, cur.rr);
        n.active = 1'b1; n.owner = w; n.rr = w; n.held = 0; n.num = v[w];
      end
    end else begin
      others   = r & ~(4'b0001 << cur.owner);
      held_now = (cur.held >= HOLD) ? HOLD : cur.held + 1;
      if ((!r[cur.owner] && others != 4'b0) ||
          (r[cur.owner] && held_now >= HOLD && others != 4'b0 && !lk[cur.owner])) begin
        w = pick(others, cur.owner);
        n.owner = w; n.rr = w; n.held = 0; n.num = v[w]; n.sw = 1'b1;
      end else if (!r[cur.owner]) begin
        n.active = 1'b0;
      end else begin
        n.held = held_now;
        n.num  = v[cur.owner];
      end
    end
    return n;
  endfunction

  // Advance the model on the same edges as the DUT, including the asynchronous reset.
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) m <= MODEL_RESET;
    else          m <= model_step(m, req, val, lock);
  end

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge pclk) begin
    if (chk_en) begin
      check_value("model gnt",     32'(gnt),     m.active ? 32'(4'b0001 << m.owner) : 32'h0);
      check_value("model owner",   32'(owner),   32'(m.owner));
      check_value("model num",     num,          m.num);
      check_value("model disp_en", 32'(disp_en), 32'(m.active));
      check_value("model switch",  32'(sw),      32'(m.sw));
    end
  end

  // Called on a falling edge. Drives the inputs and waits through the next rising edge to the following falling edge.
  task automatic apply_stimulus(input logic [3:0] r, input int cycles);
    req = r;
    for (int i = 0; i < cycles; i++) begin
      @(posedge pclk);
      @(negedge pclk);
    end
  endtask

  initial begin
    logic [3:0] table_req [17];
    table_req = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b1100,
                  4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0111, 4'b0000};
    presetn = 1'b1;
    req     = 4'b0;
    lock    = 4'b0;
    val[0]  = 32'h12345678;
    val[1]  = 32'hAAAA0001;
    val[2]  = 32'hCAFE0002;
    val[3]  = 32'hBEEF0003;
    #1 presetn = 1'b0;
    #2;
    check_value("reset gnt", 32'(gnt), 32'h0);
    check_value("reset num", num, 32'h0);
    check_value("reset disp_en", 32'(disp_en), 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    chk_en  = 1'b1;

    // Scenario 1: first arbitration after reset.
    apply_stimulus(4'b0101, 1);
    check_value("arb gnt", 32'(gnt), 32'h1);
    check_value("arb owner", 32'(owner), 32'h0);
    check_value("arb num", num, 32'h12345678);
    check_value("arb disp_en", 32'(disp_en), 32'h1);
    check_value("arb switch", 32'(sw), 32'h0);

    // Scenario 2: minimum hold of 4 cycles, followed by a handover to requester 2.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(4'b0101, 1);
      check_value("hold gnt", 32'(gnt), 32'h1);
    end
    apply_stimulus(4'b0101, 1);
    check_value("handover gnt", 32'(gnt), 32'h4);
    check_value("handover switch", 32'(sw), 32'h1);
    check_value("handover num", num, 32'hCAFE0002);
    apply_stimulus(4'b0101, 1);
    check_value("handover pulse", 32'(sw), 32'h0);

    // Scenario 3: switch back to requester 0, which then releases during its 2nd hold cycle.
    apply_stimulus(4'b0001, 2);
    apply_stimulus(4'b0000, 1);
    check_value("release gnt", 32'(gnt), 32'h0);
    check_value("release disp_en", 32'(disp_en), 32'h0);
    check_value("release num", num, 32'h12345678);

    // Scenario 4: after owner 3 reaches OPEN, the search wraps around to requester 0.
    apply_stimulus(4'b1000, 6);
    apply_stimulus(4'b1001, 1);
    check_value("wrap gnt a", 32'(gnt), 32'h1);
    apply_stimulus(4'b1000, 6);
    apply_stimulus(4'b1011, 1);
    check_value("wrap gnt b", 32'(gnt), 32'h1);

`ifdef SEG7_ARB_LOCK_EN
    // Scenario 5: a locked owner is not preempted until its lock drops.
    apply_stimulus(4'b0000, 1);
    apply_stimulus(4'b0001, 1);
    lock = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(4'b0011, 1);
      check_value("lock gnt", 32'(gnt), 32'h1);
    end
    lock = 4'b0000;
    apply_stimulus(4'b0011, 1);
    check_value("unlock gnt", 32'(gnt), 32'h2);
`endif

    // Mixed directed sequence, checked only against the model.
    foreach (table_req[k]) begin
      val[k % NR] = 32'hD0000000 | 32'(k);
      apply_stimulus(table_req[k], 1);
    end

    // Scenario 6: asynchronous reset asserted between clock edges during HOLD.
    apply_stimulus(4'b1111, 2);
    #3 presetn = 1'b0;
    #1;
    check_value("async gnt", 32'(gnt), 32'h0);
    check_value("async owner", 32'(owner), 32'h0);
    check_value("async num", num, 32'h0);
    check_value("async disp_en", 32'(disp_en), 32'h0);
    check_value("async switch", 32'(sw), 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    apply_stimulus(4'b1111, 1);
    check_value("post-reset gnt", 32'(gnt), 32'h1);
    apply_stimulus(4'b0000, 3);

    chk_en = 1'b0;
    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
